// File: rtl/uart_tx_arb_pkg.sv
// Shared types and sizing helpers for the uart_tx_arbiter block.
package uart_tx_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  // Counters only ever reach (limit - 1), so $clog2 of the largest limit is enough.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(256, 16, 65535);

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_i+1.
module uart_tx_arb_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_i) + k) % NUM_REQ;
      if (!found && req_i[IDX_W'(idx)]) begin
        found                 = 1'b1;
        win_o[IDX_W'(idx)]    = 1'b1;
        win_idx_o             = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uarttx byte transmitter among NUM_REQ requesters.
// Optional watchdog on the transmitter completion: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned SEND_HOLD      = 256,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 tx_send_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_done_i
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(SEND_HOLD, GAP_CYCLES, TIMEOUT_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] own_q, own_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [7:0]         data_q, data_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               pend_q, pend_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic               tx_rise;
  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic [7:0]         win_byte;
  logic               send_last, gap_last;

  // tx_done is asynchronous; only its synchronized rising edge is used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= tx_done_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tx_rise = sync2_q & ~sync3_q;

  uart_tx_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i     (req_i),
    .last_i    (last_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  always_comb begin
    win_byte = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_byte = req_data_i[8*i +: 8];
    end
  end

  assign send_last = (32'(cnt_q) + 32'd1) >= SEND_HOLD;
  assign gap_last  = (32'(cnt_q) + 32'd1) >= GAP_CYCLES;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
  logic             wdog_last;

  assign wdog_last = (32'(wdog_q) + 32'd1) >= TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_d   = own_q;
    data_d  = data_q;
    send_d  = send_q;
    pend_d  = pend_q;
    grant_d = '0;
    done_d  = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wdog_d  = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (|req_i) begin
          data_d  = win_byte;
          grant_d = win;
          own_d   = win;
          last_d  = win_idx;
          send_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // A completion seen this early is remembered so WAIT cannot miss it.
        if (tx_rise) pend_d = 1'b1;
        if (send_last) begin
          send_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (tx_rise || pend_q) begin
          done_d  = own_q;
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_GAP;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wdog_last) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_last) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      own_q   <= '0;
      data_q  <= 8'h00;
      send_q  <= 1'b0;
      pend_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
      data_q  <= data_d;
      send_q  <= send_d;
      pend_q  <= pend_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign grant_o   = grant_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign tx_send_o = send_q;
  assign tx_data_o = data_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single `uarttx` byte transmitter between `NUM_REQ` independent requesters. Selects one pending requester round-robin and latches its byte. It then drives the transmitter's `send`/`tx_data` inputs and waits for the transmitter's `donetx` before releasing the resource. It sits between the system-clock-domain producers and the baud-clocked transmitter, and owns all sequencing of that transmitter.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8
- `SEND_HOLD`, 256 — system-clock cycles `tx_send` is held high; must be ≥ 2 transmitter slow-clock periods
- `GAP_CYCLES`, 16 — idle cycles after each frame before the next arbitration
- `TIMEOUT_CYCLES`, 65535 — watchdog limit while waiting for `tx_done` (timeout build only)
- `clk` in 1 — system clock
- `rst_n` in 1 — synchronous, active-low reset
- `req` in `NUM_REQ` — level request per requester, held until `grant`
- `req_data` in `8*NUM_REQ` — byte for requester i at `[8*i+7:8*i]`
- `grant` out `NUM_REQ` — one-hot, 1-cycle pulse when the byte is accepted
- `done` out `NUM_REQ` — one-hot, 1-cycle pulse when the frame completes
- `busy` out 1 — high whenever state ≠ IDLE
- `err` out 1 — 1-cycle pulse on watchdog expiry
- `tx_send` out 1 — to transmitter `send`
- `tx_data` out 8 — to transmitter `tx_data`
- `tx_done` in 1 — from transmitter `donetx`; asynchronous to `clk`

## Operation
- `tx_done` passes through a 2-flop synchronizer and a rising-edge detector. Only the detected edge is used.
- States:
  - IDLE:
    - If `req` ≠ 0, pick winner `w` = first set bit searching upward, with wrap, from `last+1`.
    - On that edge: latch `tx_data` ← `req_data[w]`, pulse `grant[w]`, set `tx_send`=1, update `last` ← `w`, go to SEND.
  - SEND:
    - Hold counter counts `SEND_HOLD` cycles.
    - At terminal count, `tx_send` ← 0 and go to WAIT.
  - WAIT:
    - On `tx_done` edge: pulse `done[w]`, go to GAP.
  - GAP:
    - Count `GAP_CYCLES`, then go to IDLE.
- `tx_data` stays stable from `grant` until the next grant.
- `req` changes after grant are ignored until IDLE.
- A `tx_done` edge detected during SEND is recorded. WAIT then completes on its next cycle, so the completion is not lost.
- Requests arriving in GAP wait; there is no preemption.
- `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.

## Timing
- Reset values:
  - `grant`=0, `done`=0, `busy`=0, `err`=0, `tx_send`=0, `tx_data`=8'h00
  - state = IDLE, counters = 0, synchronizer flops = 0
- `req` seen at edge N:
  - `grant`, `tx_send`, `tx_data` valid after edge N (one-cycle latency).
  - `busy` rises on the same edge.
- `tx_send` high for exactly `SEND_HOLD` cycles.
- `done` pulses 3 cycles after the raw `tx_done` rise: 2 synchronizer flops plus 1 edge-detect register.
- Minimum spacing between grants = `SEND_HOLD` + frame time + 3 + `GAP_CYCLES` + 1.
- Reset mid-operation: next edge returns all outputs to reset values. No `done` is issued for the aborted frame.
- The transmitter resets separately and must also be reset.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A watchdog counts in WAIT.
  - At `TIMEOUT_CYCLES` with no `tx_done` edge: pulse `err`, no `done`, go to GAP.
- Undefined:
  - WAIT waits indefinitely.
  - `err` is tied 0 and the watchdog counter is not built.

## Structure
- Package `uart_tx_arb_pkg`:
  - state enum (IDLE, SEND, WAIT, GAP)
  - counter-width localparam, derived by `$clog2` from the largest of `SEND_HOLD`/`GAP_CYCLES`/`TIMEOUT_CYCLES`
- Sub-module `uart_tx_arb_rr_pick`:
  - combinational round-robin picker
  - inputs `req`, `last`; outputs one-hot `win` and index `win_idx`
- Top level holds the FSM, counters, synchronizer and data mux.

## Test plan
- Reset then single request: `req`=4'b0010, byte 8'hA5.
  - `grant`=4'b0010 one cycle later, `tx_data`=8'hA5.
  - `tx_send` high 256 cycles.
  - `tx_done` pulse → `done`=4'b0010 3 cycles later.
- All four requesting continuously, bytes 8'h10..8'h13:
  - grants in order 0,1,2,3,0.
  - each grant only after the previous `done` plus 16 gap cycles.
- Requester 2 drops `req` the cycle after its grant:
  - frame still completes, `done[2]` pulses, `tx_data` unchanged throughout.
- `rst_n` low during SEND:
  - next edge `tx_send`=0, `busy`=0, no `done`.
  - After release, requester 0 wins first.
- Timeout build, `TIMEOUT_CYCLES`=100, `tx_done` never asserted:
  - `err` pulses 100 cycles into WAIT, no `done`.
  - Next request is granted after the gap.
- `tx_done` glitch-free pulse arriving 1 cycle after `tx_send` falls:
  - `done` still issued exactly once, no double completion.
